// File: rtl/imem_responder.sv
// imem_responder
// ---------------------------------------------------------------------------
// Instruction-memory responder that sits behind the fetch stage. It issues one
// req/ack read per fetched word address, hands the returned instruction (with
// its word address) to decode, and drives the front-end pipeline enable. That
// enable stalls fetch on bus wait states and on decode back-pressure.
//
// Ports
//   clk        : clock, all state updates on posedge
//   rst        : synchronous active-high reset
//   inst_addr  : [29:0] next word address from fetch (combinational there)
//   flush      : taken jump, only meaningful on edges with pipe_en=1
//   pipe_en    : pipeline enable, feeds fetch clock enable
//   mem_req    : bus read request
//   mem_addr   : [29:0] registered bus word address
//   mem_ack    : bus read complete, mem_rdata valid this cycle
//   mem_rdata  : [31:0] bus read data
//   dec_stall  : decode cannot take a new word this cycle
//   inst       : [31:0] registered instruction word to decode
//   inst_pc    : [29:0] registered word address of inst
//   inst_valid : inst/inst_pc hold a live word
// ---------------------------------------------------------------------------
module imem_responder (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] inst_addr,
  input  logic        flush,
  output logic        pipe_en,
  output logic        mem_req,
  output logic [29:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        dec_stall,
  output logic [31:0] inst,
  output logic [29:0] inst_pc,
  output logic        inst_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [29:0] mem_addr_reg;
  logic [31:0] inst_reg;
  logic [29:0] inst_pc_reg;
  logic        inst_valid_reg;
  logic [31:0] hold_data_reg;

  logic busy;   // decode still owns a live word it cannot take yet
  logic load;   // word moves into inst this edge
  logic park;   // bus returned data while decode is blocked

  assign busy = inst_valid_reg && dec_stall;
  assign load = !rst && pipe_en && (state_reg != IDLE);
  assign park = (state_reg == REQ) && mem_ack && busy;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (!busy) state_next = REQ;
      end
      REQ: begin
        // A zero-wait ack with decode free stays in REQ for the next address.
        if (mem_ack) state_next = busy ? HOLD : REQ;
      end
      HOLD: begin
        if (!busy) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    pipe_en = 1'b1;
    mem_req = (state_reg == REQ);
    // Enable stays high through reset so fetch can reset under its clock enable.
    if (!rst) begin
      case (state_reg)
        IDLE:    pipe_en = !busy;
        REQ:     pipe_en = mem_ack && !busy;
        HOLD:    pipe_en = !busy;
        default: pipe_en = 1'b1;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr_reg   <= 30'd0;
      inst_reg       <= 32'd0;
      inst_pc_reg    <= 30'd0;
      inst_valid_reg <= 1'b0;
      hold_data_reg  <= 32'd0;
    end else begin
      // Every enabled edge moves fetch forward, so the next request address
      // is captured whenever the pipeline advances.
      if (pipe_en) mem_addr_reg <= inst_addr;

      if (park) hold_data_reg <= mem_rdata;

      if (load) begin
        inst_reg       <= (state_reg == HOLD) ? hold_data_reg : mem_rdata;
        inst_pc_reg    <= mem_addr_reg;
        inst_valid_reg <= !flush;          // a jump drops the word in flight
      end else if (!dec_stall) begin
        inst_valid_reg <= 1'b0;            // word consumed, nothing new
      end
    end
  end

  assign mem_addr   = mem_addr_reg;
  assign inst       = inst_reg;
  assign inst_pc    = inst_pc_reg;
  assign inst_valid = inst_valid_reg;

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder on the far side of the fetch stage. Each cycle the pipeline advances, it accepts the 30-bit word address from the fetch stage and runs a req/ack read on the instruction bus. It then returns the 32-bit instruction word with its address to decode. It drives the global pipeline enable, so the fetch stage and the rest of the front end stall on bus wait states and on decode back-pressure.

## Interface
Parameters: none; widths are fixed (30-bit word address, 32-bit instruction).

Ports:
- clk  in  1  sole clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- inst_addr  in  30  next word address from fetch stage (combinational on its side)
- flush  in  1  taken jump; sampled only on edges where pipe_en=1
- pipe_en  out  1  pipeline enable; drives fetch clk_en
- mem_req  out  1  bus read request
- mem_addr  out  30  bus word address, registered
- mem_ack  in  1  bus read complete; mem_rdata valid this cycle
- mem_rdata  in  32  bus read data
- dec_stall  in  1  decode cannot accept a new word this cycle
- inst  out  32  instruction word to decode, registered
- inst_pc  out  30  word address of inst, registered
- inst_valid  out  1  inst/inst_pc hold a live word

## Operation
- States: IDLE, REQ, HOLD. Registers: state, mem_addr, inst, inst_pc, inst_valid, hold_data.
- busy = inst_valid && dec_stall.
- pipe_en (combinational):
  - 1 while rst=1, so fetch can reset under its clock enable.
  - IDLE: !busy.
  - REQ: mem_ack && !busy.
  - HOLD: !busy.
- mem_req = (state==REQ). mem_addr is stable for the whole REQ dwell.
- A "load" is an edge with pipe_en=1 in REQ or HOLD:
  - inst <= mem_rdata in REQ, or hold_data in HOLD.
  - inst_pc <= mem_addr.
  - inst_valid <= !flush; a flushed word is dropped and never reaches decode.
  - mem_addr <= inst_addr, state <= REQ.
- IDLE, edge with pipe_en=1: mem_addr <= inst_addr, state <= REQ. No word is loaded.
- REQ, edge with mem_ack=1 && busy: hold_data <= mem_rdata, state <= HOLD. mem_req drops the next cycle.
- REQ, edge with mem_ack=0: no change.
- Any non-load edge with !dec_stall: inst_valid <= 0, because the word was consumed.
- Any edge with busy: inst, inst_pc and inst_valid hold.
- flush on an edge with pipe_en=0 is ignored. The jump source holds flush until pipe_en=1.
- rst (synchronous) overrides everything:
  - state <= IDLE, mem_addr <= 0, inst <= 0, inst_pc <= 0, inst_valid <= 0, hold_data <= 0.
  - An in-flight bus read is abandoned; the bus tolerates mem_req dropping before mem_ack.
- mem_ack while mem_req=0 is ignored.

## Timing
- Reset values: mem_req=0, mem_addr=0, inst=0, inst_pc=0, inst_valid=0. pipe_en=1 during and after reset.
- Zero-wait bus (mem_ack in the first REQ cycle): one instruction per cycle; pipe_en stays 1.
- First edge E0 with rst=0: the request for address 0 is launched. The word at address 0 is visible after E1 (inst_valid=1, inst_pc=0).
- N wait cycles (mem_ack N cycles after mem_req rises):
  - pipe_en is low for N cycles.
  - The word is loaded on the edge of the ack cycle; latency is N+1 cycles from request to inst_valid.
- Decode stall while ack arrives: the word is parked in HOLD. It is loaded on the first edge with dec_stall=0, then the next request issues.
- Invariant: mem_addr equals the fetch stage's current ip whenever state is REQ or HOLD.
- At most one bus read is outstanding. At most one word is buffered beyond inst.

## Test plan
- Reset then zero-wait bus returning mem_rdata = 0xA000_0000 | addr -> inst_valid rises after E1; inst_pc reads 0,1,2,3 on consecutive cycles; inst = 0xA0000000..0xA0000003; pipe_en constantly 1.
- mem_ack delayed 3 cycles on address 5 -> pipe_en low 3 cycles; mem_addr holds 5; inst_pc=5 appears one edge after ack; no address is skipped or duplicated.
- dec_stall=1 for 2 cycles while inst_pc=7 is valid and the bus acks address 8 -> HOLD entered; inst stays at pc 7; mem_req=0; after stall release, inst_pc=8 is loaded, then the request for 9 issues.
- Jump: flush=1 on the load edge of address 4 with inst_addr=0x100 -> address 4 is never valid; the next mem_addr is 0x100; the next valid inst_pc is 0x100.
- rst asserted in REQ with mem_ack=0 on address 12 -> next cycle: mem_req=0, inst_valid=0, mem_addr=0, pipe_en=1; a late mem_ack is ignored; after release, fetch restarts from address 0.
- flush=1 while pipe_en=0 (wait state) -> no effect; the word is delivered normally once acked, unless flush is still high on the load edge.
